stream_ctrl: RTL and testbench

Parametrised run controller that starts, throttles and drains one of N_CH data producers feeding the shared clock-domain-crossing buffer. It replaces the fixed two-source start/stop controller with a channel-vector generalisation. It adds deterministic priority for simultaneous starts, direct channel switching through a drain phase, and a drain timeout with a sticky error flag. It sits at the top level between the raw push-button inputs and the producer enables and buffer status.

---
 rtl/stream_ctrl_pkg.sv | 21 ++
 rtl/stream_ctrl_rise.sv | 25 ++
 rtl/stream_ctrl.sv | 130 +++++++++++++
 tb/tb_stream_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/stream_ctrl_pkg.sv
// Shared types and helpers for the stream run controller: state encoding,
// state_led bit positions and lowest-set-index selection.
package stream_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, RUN, WAIT, DRAIN} state_t;

    localparam int LED_IDLE  = 0;
    localparam int LED_RUN   = 1;
    localparam int LED_WAIT  = 2;
    localparam int LED_DRAIN = 3;

    // Upper bound on channel count; callers zero-extend their vectors.
    localparam int MAX_CH = 64;

    function automatic int unsigned lowest_idx(input logic [MAX_CH-1:0] v);
        lowest_idx = 0;
        for (int i = MAX_CH - 1; i >= 0; i--)
            if (v[i]) lowest_idx = i;
    endfunction

endpackage

// File: rtl/stream_ctrl_rise.sv
// Vector rising-edge detector: two flops per bit, rise = d_q & ~d_qq.
module rise_det #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] rise
);

    logic [W-1:0] d_q, d_qq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q  <= '0;
            d_qq <= '0;
        end else begin
            d_q  <= d;
            d_qq <= d_q;
        end
    end

    assign rise = d_q & ~d_qq;

endmodule

// File: rtl/stream_ctrl.sv
// Run controller: starts, throttles and drains one of N_CH producers feeding
// the shared CDC buffer, with channel switching through a timed drain phase.
module stream_ctrl
    import stream_ctrl_pkg::*;
#(
    parameter int N_CH     = 2,
    parameter int DRAIN_TO = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         start,
    input  logic                    stop,
    input  logic                    buf_full,
    input  logic                    buf_empty,
    input  logic                    rd_valid,
    output logic [N_CH-1:0]         ch_en,
    output logic [$clog2(N_CH)-1:0] ch_idx,
    output logic [3:0]              state_led,
    output logic                    drain_err
);

    localparam int IW = $clog2(N_CH);
    localparam int CW = $clog2(DRAIN_TO + 1);
    localparam logic [N_CH-1:0] ONE = {{(N_CH-1){1'b0}}, 1'b1};

    state_t          state_q, state_d;
    logic [IW-1:0]   cur_q, cur_d, pend_q, pend_d;
    logic            pend_vld_q, pend_vld_d;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic            err_q, err_d;
    logic [N_CH-1:0] start_rise, sw, cur_oh, ch_en_d;
    logic            stop_rise, done, pend_live;

    rise_det #(.W(N_CH)) u_start_rd (.clk(clk), .rst(rst), .d(start), .rise(start_rise));
    rise_det #(.W(1))    u_stop_rd  (.clk(clk), .rst(rst), .d(stop),  .rise(stop_rise));

    assign cur_oh    = ONE << cur_q;
    assign sw        = start_rise & ~cur_oh;
    assign done      = buf_empty & ~rd_valid;
    assign pend_live = pend_vld_q & ~stop_rise;
    assign cnt_inc   = (cnt_q == CW'(DRAIN_TO)) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (|start_rise) begin
                    state_d = RUN;
                    cur_d   = IW'(lowest_idx(MAX_CH'(start_rise)));
                    err_d   = 1'b0;
                end
            end
            RUN, WAIT: begin
                if (stop_rise) begin
                    state_d    = DRAIN;
                    pend_vld_d = 1'b0;
                    cnt_d      = '0;
                end else if (|sw) begin
                    state_d    = DRAIN;
                    pend_vld_d = 1'b1;
                    pend_d     = IW'(lowest_idx(MAX_CH'(sw)));
                    cnt_d      = '0;
                end else if (state_q == RUN && buf_full) begin
                    state_d = WAIT;
                end else if (state_q == WAIT && !buf_full) begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                // Done wins over timeout when both land in the same cycle.
                if (done) begin
                    state_d    = pend_live ? RUN : IDLE;
                    cur_d      = pend_live ? pend_q : cur_q;
                    pend_vld_d = 1'b0;
                end else if (cnt_inc == CW'(DRAIN_TO)) begin
                    state_d    = IDLE;
                    err_d      = 1'b1;
                    pend_vld_d = 1'b0;
                    cnt_d      = cnt_inc;
                end else begin
                    cnt_d      = cnt_inc;
                    pend_vld_d = pend_live;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ch_en_d = (state_d == RUN) ? (ONE << cur_d) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cur_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            ch_en      <= '0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            ch_en      <= ch_en_d;
        end
    end

    always_comb begin
        state_led = '0;
        case (state_q)
            IDLE:    state_led[LED_IDLE]  = 1'b1;
            RUN:     state_led[LED_RUN]   = 1'b1;
            WAIT:    state_led[LED_WAIT]  = 1'b1;
            DRAIN:   state_led[LED_DRAIN] = 1'b1;
            default: state_led = '0;
        endcase
    end

    assign ch_idx    = cur_q;
    assign drain_err = err_q;

endmodule

// File: tb/tb_stream_ctrl.sv
// Directed bench for stream_ctrl (N_CH=4, DRAIN_TO=16); inputs change and
// outputs are sampled on the falling edge.
module tb_stream_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] start = '0;
    logic       stop = 1'b0, buf_full = 1'b0, buf_empty = 1'b1, rd_valid = 1'b0;
    logic [3:0] ch_en;
    logic [1:0] ch_idx;
    logic [3:0] state_led;
    logic       drain_err;

    int n_chk = 0;
    int n_fail = 0;

    stream_ctrl #(.N_CH(4), .DRAIN_TO(16)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .buf_full(buf_full), .buf_empty(buf_empty), .rd_valid(rd_valid),
        .ch_en(ch_en), .ch_idx(ch_idx), .state_led(state_led), .drain_err(drain_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        tick(2);
        chk("rst_led", 32'(state_led), 32'h1);
        chk("rst_en",  32'(ch_en), 32'h0);
        chk("rst_idx", 32'(ch_idx), 32'h0);
        chk("rst_err", 32'(drain_err), 32'h0);
        rst = 1'b0;
        tick(1);

        // Simultaneous starts 1 and 2: lowest wins, two edges of latency.
        start = 4'b0110;
        tick(1);
        chk("s1_lat_led", 32'(state_led), 32'h1);
        chk("s1_lat_en",  32'(ch_en), 32'h0);
        tick(1);
        chk("s1_led", 32'(state_led), 32'h2);
        chk("s1_idx", 32'(ch_idx), 32'h1);
        chk("s1_en",  32'(ch_en), 32'b0010);
        tick(2);
        chk("s1_held", 32'(state_led), 32'h2);
        start = '0;
        stop = 1'b1;
        tick(2);
        chk("s1_drain", 32'(state_led), 32'h8);
        chk("s1_drain_en", 32'(ch_en), 32'h0);
        stop = 1'b0;
        tick(1);
        chk("s1_idle", 32'(state_led), 32'h1);

        // Throttle through WAIT.
        start = 4'b0001;
        tick(2);
        chk("s2_run_idx", 32'(ch_idx), 32'h0);
        chk("s2_run_en",  32'(ch_en), 32'h1);
        start = '0;
        buf_full = 1'b1;
        tick(1);
        chk("s2_wait", 32'(state_led), 32'h4);
        chk("s2_wait_en", 32'(ch_en), 32'h0);
        tick(4);
        chk("s2_wait5", 32'(state_led), 32'h4);
        buf_full = 1'b0;
        tick(1);
        chk("s2_resume", 32'(state_led), 32'h2);
        chk("s2_resume_en", 32'(ch_en), 32'h1);

        // Switch to ch2 through a 3-cycle drain.
        buf_empty = 1'b0;
        start = 4'b0100;
        tick(2);
        chk("s3_drain", 32'(state_led), 32'h8);
        chk("s3_drain_en", 32'(ch_en), 32'h0);
        tick(1);
        chk("s3_drain2", 32'(state_led), 32'h8);
        tick(1);
        chk("s3_drain3", 32'(state_led), 32'h8);
        buf_empty = 1'b1;
        tick(1);
        chk("s3_run", 32'(state_led), 32'h2);
        chk("s3_idx", 32'(ch_idx), 32'h2);
        chk("s3_en",  32'(ch_en), 32'b0100);
        start = '0;
        tick(1);

        // Stop beats a same-cycle switch request.
        stop = 1'b1;
        start = 4'b0010;
        tick(2);
        chk("s4_drain", 32'(state_led), 32'h8);
        tick(1);
        chk("s4_idle", 32'(state_led), 32'h1);
        chk("s4_idx",  32'(ch_idx), 32'h2);
        chk("s4_en",   32'(ch_en), 32'h0);
        stop = 1'b0;
        start = '0;
        tick(1);

        // Drain timeout after 16 DRAIN cycles.
        start = 4'b0001;
        tick(2);
        chk("s5_run", 32'(state_led), 32'h2);
        start = '0;
        buf_empty = 1'b0;
        stop = 1'b1;
        tick(2);
        chk("s5_drain", 32'(state_led), 32'h8);
        stop = 1'b0;
        tick(15);
        chk("s5_drain16", 32'(state_led), 32'h8);
        chk("s5_err_pre", 32'(drain_err), 32'h0);
        tick(1);
        chk("s5_to_idle", 32'(state_led), 32'h1);
        chk("s5_err", 32'(drain_err), 32'h1);
        buf_empty = 1'b1;
        start = 4'b1000;
        tick(1);
        chk("s5_err_hold", 32'(drain_err), 32'h1);
        tick(1);
        chk("s5_run3", 32'(ch_idx), 32'h3);
        chk("s5_err_clr", 32'(drain_err), 32'h0);

        // Reset during DRAIN with ch3 pending.
        start = 4'b0001;
        tick(2);
        tick(1);
        chk("s6_run0", 32'(ch_en), 32'h1);
        start = '0;
        buf_empty = 1'b0;
        tick(1);
        start = 4'b1000;
        tick(2);
        chk("s6_drain", 32'(state_led), 32'h8);
        tick(1);
        #2 rst = 1'b1;
        #1;
        chk("s6_rst_led", 32'(state_led), 32'h1);
        chk("s6_rst_en",  32'(ch_en), 32'h0);
        chk("s6_rst_idx", 32'(ch_idx), 32'h0);
        start = '0;
        buf_empty = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(5);
        chk("s6_no_run", 32'(state_led), 32'h1);
        chk("s6_no_en",  32'(ch_en), 32'h0);
        start = 4'b0100;
        tick(2);
        chk("s6_new_run", 32'(ch_en), 32'b0100);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
